// File: rtl/cnn_out_sink.sv
// Receive-side FIFO for the cnn output stream with frame counting and sticky overflow.
// Optional feature macro: CNN_SINK_RELU_EN (negative bytes are stored as zero).
module cnn_out_sink #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned FRAME_LEN = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_en,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          frame_done
);

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [7:0]  FRAME_TOP = 8'(FRAME_LEN - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          full_w, empty_w, wr, rd, drop;
  logic [7:0]    wdata;

  always_comb begin
`ifdef CNN_SINK_RELU_EN
    wdata = in_data[7] ? '0 : in_data;
`else
    wdata = in_data;
`endif
  end

  always_comb begin
    full_w       = (count_q == DEPTH_C);
    empty_w      = (count_q == '0);
    // A full FIFO still accepts a write when the same cycle frees a slot.
    wr           = in_en & (~full_w | rd_en);
    rd           = rd_en & ~empty_w;
    drop         = in_en & full_w & ~rd_en;

    wp_d         = wp_q;
    rp_d         = rp_q;
    count_d      = count_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd;
    ovf_d        = ovf_q;
    fcnt_d       = fcnt_q;
    frame_done_d = 1'b0;

    if (wr) wp_d = wp_q + 1'b1;
    if (rd) begin
      rp_d      = rp_q + 1'b1;
      rd_data_d = mem[rp_q];
    end

    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    if (wr) begin
      if (fcnt_q == FRAME_TOP) begin
        fcnt_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_out_sink.sv
// Directed self-checking bench for cnn_out_sink (DEPTH=8, FRAME_LEN=9).
module tb_cnn_out_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, ovf, frame_done;
  logic [3:0] count;

  int unsigned total = 0;
  int unsigned bad = 0;

  cnn_out_sink #(.DEPTH(8), .AW(3), .FRAME_LEN(9)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .count(count), .ovf(ovf), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; in_data = '0;
    rst = 1'b0;
    #7;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 4'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 8'h00)  begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
  endtask

  task automatic test_single();
    do_reset();
    in_data = 8'd16; in_en = 1'b1;
    step();
    in_en = 1'b0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%0b exp=0", empty); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_no_valid got=%0b exp=0", rd_valid); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%0b exp=1", rd_valid); end
    total++; if (rd_data !== 8'd16) begin bad++; $display("FAIL single_rd_data got=%0d exp=16", rd_data); end
    total++; if (count !== 4'd0)    begin bad++; $display("FAIL single_count_after got=%0d exp=0", count); end
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 8'd16) begin bad++; $display("FAIL single_rd_hold got=%0d exp=16", rd_data); end
  endtask

  task automatic test_order();
    logic [7:0] vals [3];
    vals[0] = 8'd16; vals[1] = 8'd32; vals[2] = 8'd8;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i]; in_en = 1'b1;
      step();
      in_en = 1'b0;
      step();
      step();
    end
    total++; if (count !== 4'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== vals[i])
        begin bad++; $display("FAIL order_rd%0d got=%0d/v%0b exp=%0d/v1", i, rd_data, rd_valid, vals[i]); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i + 1); in_en = 1'b1;
      step();
      if (i == 6) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL ovf_full_early got=%0b exp=0", full); end
      end
    end
    total++; if (full !== 1'b1)  begin bad++; $display("FAIL ovf_full got=%0b exp=1", full); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count8 got=%0d exp=8", count); end
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL ovf_early got=%0b exp=0", ovf); end
    in_data = 8'd99;
    step();
    in_en = 1'b0;
    total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count_drop got=%0d exp=8", count); end
    step();
    total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
  endtask

  // Relies on test_overflow leaving 1..8 stored and ovf cleared.
  task automatic test_back_to_back();
    in_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(101 + i);
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1) || count !== 4'd8)
        begin bad++; $display("FAIL b2b_%0d got=%0d/v%0b/c%0d exp=%0d/v1/c8", i, rd_data, rd_valid, count, i + 1); end
    end
    in_en = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_no_drop got=%0b exp=0", ovf); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (rd_data !== 8'(101 + i))
        begin bad++; $display("FAIL b2b_drain%0d got=%0d exp=%0d", i, rd_data, 101 + i); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_frame();
    do_reset();
    in_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'(200 + i);
      step();
      if (i == 0) begin
        total++; if (rd_valid !== 1'b0 || count !== 4'd1)
          begin bad++; $display("FAIL frame_empty_rw got=v%0b/c%0d exp=v0/c1", rd_valid, count); end
      end
      total++; if (frame_done !== (i == 8))
        begin bad++; $display("FAIL frame_done_%0d got=%0b exp=%0b", i, frame_done, (i == 8)); end
    end
    in_en = 1'b0; rd_en = 1'b0;
    step();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_pulse got=%0b exp=0", frame_done); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 1); in_en = 1'b1;
      step();
    end
    in_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (count !== 4'd5 || rd_data !== 8'd1)
      begin bad++; $display("FAIL arst_pre got=c%0d/d%0d exp=c5/d1", count, rd_data); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'd0 ||
                 rd_valid !== 1'b0 || ovf !== 1'b0 || frame_done !== 1'b0)
      begin bad++; $display("FAIL arst_now got=c%0d/e%0b/d%0d/v%0b exp=c0/e1/d0/v0", count, empty, rd_data, rd_valid); end
    @(negedge clk);
    rst = 1'b1;
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL arst_after got=%0d exp=0", count); end
    in_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'(50 + i);
      step();
      total++; if (frame_done !== (i == 8))
        begin bad++; $display("FAIL arst_frame_%0d got=%0b exp=%0b", i, frame_done, (i == 8)); end
    end
    in_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_relu();
    logic [7:0] exp_neg;
`ifdef CNN_SINK_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h90;
`endif
    do_reset();
    in_en = 1'b1;
    in_data = 8'h90; step();
    in_data = 8'h7F; step();
    in_en = 1'b0;
    total++; if (count !== 4'd2) begin bad++; $display("FAIL relu_count got=%0d exp=2", count); end
    rd_en = 1'b1;
    step();
    total++; if (rd_data !== exp_neg) begin bad++; $display("FAIL relu_neg got=%0h exp=%0h", rd_data, exp_neg); end
    step();
    rd_en = 1'b0;
    total++; if (rd_data !== 8'h7F) begin bad++; $display("FAIL relu_pos got=%0h exp=7f", rd_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_back_to_back();
    test_frame();
    test_async_reset();
    test_relu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
